// File: rtl/apb_fifo_pkg.sv
// Shared register offsets, bit positions and FSM encoding for the APB byte-FIFO responder.
package apb_fifo_pkg;
  localparam logic [3:0] TXDATA_OFS = 4'h0;
  localparam logic [3:0] CTRL_OFS   = 4'h4;
  localparam logic [3:0] STATUS_OFS = 4'h8;
  localparam logic [3:0] RXDATA_OFS = 4'hC;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_CLR_BIT     = 1;
  localparam int STATUS_EMPTY_BIT = 6;
  localparam int STATUS_FULL_BIT  = 7;
  localparam int STATUS_COUNT_LSB = 8;

  typedef enum logic {IDLE, ACCESS} state_t;
endpackage

// File: rtl/apb_fifo_slave_byte_fifo.sv
// Circular byte FIFO with synchronous clear; overflowing pushes and underflowing pops are ignored.
module byte_fifo #(
  parameter int DEPTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clr,
  input  logic [7:0]                 din,
  output logic [7:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rptr];

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= ptr_next(wptr);
      if (pop_ok)  rptr <= ptr_next(rptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end
endmodule

// File: rtl/apb_fifo_slave.sv
// APB3/APB4 completer exposing a byte FIFO through TXDATA/CTRL/STATUS/RXDATA with fixed wait states.
module apb_fifo_slave
  import apb_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 5,
  parameter int WAIT_STATES = 1
) (
  input  logic                    PCLK,
  input  logic                    PReset,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PSELx,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH/8-1:0] PWSTRB,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CW     = $clog2(FIFO_DEPTH + 1);
  localparam int WW     = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  state_t          state;
  state_t          state_nxt;
  logic [WW-1:0]   wcnt;
  logic [3:0]      addr;
  logic            write;
  logic            strb0;
  logic [7:0]      wbyte;
  logic            en;
  logic            setup;
  logic            ready;
  logic            err;
  logic            commit;
  logic            ok;
  logic            push;
  logic            pop;
  logic            clr;
  logic            ctrl_wr;
  logic [7:0]      fifo_dout;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic [DATA_WIDTH-1:0] rdata;
  logic            unused_bits;

  // Only the low address nibble and byte lane 0 carry meaning.
  assign unused_bits = ^{PADDR[ADDR_WIDTH-1:4], PWSTRB[STRB_W-1:1], PWDATA[DATA_WIDTH-1:8]};

  assign setup  = (state == IDLE) && PSELx && !PENABLE;
  assign ready  = (state == ACCESS) && (wcnt == '0);
  assign commit = ready && PSELx && PENABLE;
  assign ok     = commit && !err;

  always_ff @(posedge PCLK) begin
    if (PReset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (setup) state_nxt = ACCESS;
      ACCESS:  if (!PSELx || commit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    PREADY  = ready;
    PSLVERR = ready && err;
    PRDATA  = (ready && !write && !err) ? rdata : '0;
  end

  always_ff @(posedge PCLK) begin
    if (PReset)                             wcnt <= '0;
    else if (setup)                         wcnt <= WW'(WAIT_STATES);
    else if (state == ACCESS && wcnt != '0) wcnt <= wcnt - 1'b1;
  end

  always_ff @(posedge PCLK) begin
    if (setup) begin
      addr  <= PADDR[3:0];
      write <= PWRITE;
      strb0 <= PWSTRB[0];
      wbyte <= PWDATA[7:0];
    end
  end

  // Errors depend on live FIFO/EN state so full/empty are judged at completion.
  always_comb begin
    err = 1'b0;
    case (addr)
      TXDATA_OFS: err = !write || (strb0 && (fifo_full || !en));
      CTRL_OFS:   err = 1'b0;
      STATUS_OFS: err = write;
      RXDATA_OFS: err = write || fifo_empty || !en;
      default:    err = 1'b1;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (addr)
      CTRL_OFS:   rdata[CTRL_EN_BIT] = en;
      STATUS_OFS: begin
        rdata[STATUS_FULL_BIT]             = fifo_full;
        rdata[STATUS_EMPTY_BIT]            = fifo_empty;
        rdata[STATUS_COUNT_LSB +: CW]      = fifo_count;
      end
      RXDATA_OFS: rdata[7:0] = fifo_dout;
      default:    rdata = '0;
    endcase
  end

  assign push    = ok && write && (addr == TXDATA_OFS) && strb0;
  assign pop     = ok && !write && (addr == RXDATA_OFS);
  assign ctrl_wr = ok && write && (addr == CTRL_OFS) && strb0;
  assign clr     = ctrl_wr && wbyte[CTRL_CLR_BIT];

  always_ff @(posedge PCLK) begin
    if (PReset)       en <= 1'b0;
    else if (ctrl_wr) en <= wbyte[CTRL_EN_BIT];
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (PCLK),
    .rst   (PReset),
    .push  (push),
    .pop   (pop),
    .clr   (clr),
    .din   (wbyte),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule
